// File: rtl/nanorv32_tcm_responder_pkg.sv
// -----------------------------------------------------------------------------
// nanorv32_tcm_responder_pkg
// Shared nanorv32 parameters for the TCM responder slice. It holds:
//   - NANORV32_DATA_MSB : MSB of the TCM data path (32-bit words)
//   - tcm_state_e       : wait-state FSM encodings (IDLE, WAIT, DONE)
//   - is_write()        : decodes a byte-select vector into read/write
// No ports; imported by the interface, the SRAM and the top.
// -----------------------------------------------------------------------------
package nanorv32_tcm_responder_pkg;

  localparam int NANORV32_DATA_MSB = 31;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } tcm_state_e;

  // Any enabled byte lane makes the access a write; none makes it a read.
  function automatic logic is_write(input logic [3:0] bytesel);
    return (bytesel != 4'b0000);
  endfunction

endpackage

// File: rtl/nanorv32_tcm_responder_if.sv
// -----------------------------------------------------------------------------
// nanorv32_tcm_responder_if
// TCM request/response bundle between the arbiter (master) and the TCM
// responder (slave).
//   tcm_en        master->slave  access request
//   tcm_addr      master->slave  byte address (bits [1:0] ignored)
//   tcm_bytesel   master->slave  byte-lane write enables, 4'b0000 = read
//   tcm_din       master->slave  write data
//   tcm_dout      slave->master  registered read data
//   tcm_ready_nxt slave->master  access completes at the next edge
// -----------------------------------------------------------------------------
interface nanorv32_tcm_responder_if #(
  parameter int ADDR_WIDTH = 12
);
  import nanorv32_tcm_responder_pkg::*;

  logic                       tcm_en;
  logic [ADDR_WIDTH-1:0]      tcm_addr;
  logic [3:0]                 tcm_bytesel;
  logic [NANORV32_DATA_MSB:0] tcm_din;
  logic [NANORV32_DATA_MSB:0] tcm_dout;
  logic                       tcm_ready_nxt;

  modport master (
    output tcm_en,
    output tcm_addr,
    output tcm_bytesel,
    output tcm_din,
    input  tcm_dout,
    input  tcm_ready_nxt
  );

  modport slave (
    input  tcm_en,
    input  tcm_addr,
    input  tcm_bytesel,
    input  tcm_din,
    output tcm_dout,
    output tcm_ready_nxt
  );

endinterface

// File: rtl/nanorv32_tcm_responder_sram.sv
// -----------------------------------------------------------------------------
// nanorv32_tcm_sram
// Single-port word array with per-byte write enables and a registered read
// port. Depth is 2^AW 32-bit words. Reset clears only the read register; the
// array contents survive reset.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (read register only)
//   en    in   execute an access at this edge
//   we    in   byte-lane write enables, 4'b0000 = read
//   addr  in   word index
//   wdata in   write data, lane n = bits [8n+7:8n]
//   rdata out  registered read data, holds across writes
// -----------------------------------------------------------------------------
module nanorv32_tcm_sram
  import nanorv32_tcm_responder_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [3:0]                 we,
  input  logic [AW-1:0]              addr,
  input  logic [NANORV32_DATA_MSB:0] wdata,
  output logic [NANORV32_DATA_MSB:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [NANORV32_DATA_MSB:0] mem_r [DEPTH];

  // Byte-lane writes into the array; deliberately no reset on storage.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int n = 0; n < 4; n++) begin
        if (we[n]) begin
          mem_r[addr][8*n +: 8] <= wdata[8*n +: 8];
        end
      end
    end
  end

  // Registered read port; a write leaves the previous read data in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !is_write(we)) begin
      rdata <= mem_r[addr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/nanorv32_tcm_responder.sv
// -----------------------------------------------------------------------------
// nanorv32_tcm_responder
// Tightly-coupled memory responder: accepts single-word accesses from the
// arbiter, executes them against nanorv32_tcm_sram and returns registered read
// data. Optional wait states are compiled in with the macro
// NANORV32_TCM_WAIT_STATES_EN; without it (or with WAIT_CYCLES=0) every
// enabled request completes at the next edge and no FSM/counter exists.
// Parameters:
//   ADDR_WIDTH   byte-address width; depth = 2^(ADDR_WIDTH-2) words
//   WAIT_CYCLES  wait cycles per access (wait-state build only)
// Ports:
//   clk  in   single clock, rising edge
//   rst  in   synchronous active-high reset
//   tcm  slave modport of nanorv32_tcm_responder_if
// -----------------------------------------------------------------------------
module nanorv32_tcm_responder
  import nanorv32_tcm_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  nanorv32_tcm_responder_if.slave    tcm
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  logic                       ready_nxt_s;
  logic                       exec_en_s;
  logic [3:0]                 exec_we_s;
  logic [IDX_W-1:0]           exec_idx_s;
  logic [NANORV32_DATA_MSB:0] exec_din_s;
  logic [NANORV32_DATA_MSB:0] dout_s;
  logic [1:0]                 unused_addr_lsb_s;

  // Byte offset within the word plays no part in word accesses.
  assign unused_addr_lsb_s = tcm.tcm_addr[1:0];

`ifdef NANORV32_TCM_WAIT_STATES_EN
  generate
    if (WAIT_CYCLES == 0) begin : g_zero_wait

      // Zero-wait: an enabled request executes straight from the bus.
      always_comb begin
        ready_nxt_s = 1'b0;
        exec_en_s   = 1'b0;
        exec_we_s   = 4'b0000;
        exec_idx_s  = tcm.tcm_addr[ADDR_WIDTH-1:2];
        exec_din_s  = tcm.tcm_din;
        if (!rst && tcm.tcm_en) begin
          ready_nxt_s = 1'b1;
          exec_en_s   = 1'b1;
          exec_we_s   = tcm.tcm_bytesel;
        end else begin
          ready_nxt_s = 1'b0;
          exec_en_s   = 1'b0;
        end
      end

    end else begin : g_wait_states

      localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
      localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

      tcm_state_e                 state_r;
      tcm_state_e                 state_nxt_s;
      logic [CNT_W-1:0]           cnt_r;
      logic [CNT_W-1:0]           cnt_nxt_s;
      logic                       lat_load_s;
      logic [IDX_W-1:0]           lat_idx_r;
      logic [3:0]                 lat_we_r;
      logic [NANORV32_DATA_MSB:0] lat_din_r;

      // FSM state, wait counter and latched request.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          lat_idx_r <= '0;
          lat_we_r  <= 4'b0000;
          lat_din_r <= '0;
        end else begin
          state_r <= state_nxt_s;
          cnt_r   <= cnt_nxt_s;
          if (lat_load_s) begin
            lat_idx_r <= tcm.tcm_addr[ADDR_WIDTH-1:2];
            lat_we_r  <= tcm.tcm_bytesel;
            lat_din_r <= tcm.tcm_din;
          end else begin
            lat_idx_r <= lat_idx_r;
            lat_we_r  <= lat_we_r;
            lat_din_r <= lat_din_r;
          end
        end
      end

      // Next state and access strobes; the access always executes from the
      // latched copy so the requester's bus may change once ready is seen.
      always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        lat_load_s  = 1'b0;
        ready_nxt_s = 1'b0;
        exec_en_s   = 1'b0;
        exec_we_s   = 4'b0000;
        exec_idx_s  = lat_idx_r;
        exec_din_s  = lat_din_r;
        if (rst) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else begin
          case (state_r)
            IDLE: begin
              if (tcm.tcm_en) begin
                lat_load_s  = 1'b1;
                cnt_nxt_s   = CNT_LOAD;
                state_nxt_s = WAIT;
              end else begin
                state_nxt_s = IDLE;
              end
            end
            WAIT: begin
              cnt_nxt_s = cnt_r - CNT_ONE;
              if (cnt_r == CNT_ONE) begin
                ready_nxt_s = 1'b1;
                exec_en_s   = 1'b1;
                exec_we_s   = lat_we_r;
                state_nxt_s = DONE;
              end else begin
                state_nxt_s = WAIT;
              end
            end
            DONE: begin
              state_nxt_s = IDLE;
            end
            default: begin
              state_nxt_s = IDLE;
              cnt_nxt_s   = '0;
            end
          endcase
        end
      end

    end
  endgenerate
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;

  // Zero-wait: an enabled request executes straight from the bus.
  always_comb begin
    ready_nxt_s = 1'b0;
    exec_en_s   = 1'b0;
    exec_we_s   = 4'b0000;
    exec_idx_s  = tcm.tcm_addr[ADDR_WIDTH-1:2];
    exec_din_s  = tcm.tcm_din;
    if (!rst && tcm.tcm_en) begin
      ready_nxt_s = 1'b1;
      exec_en_s   = 1'b1;
      exec_we_s   = tcm.tcm_bytesel;
    end else begin
      ready_nxt_s = 1'b0;
      exec_en_s   = 1'b0;
    end
  end
`endif

  nanorv32_tcm_sram #(
    .AW (IDX_W)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .en    (exec_en_s),
    .we    (exec_we_s),
    .addr  (exec_idx_s),
    .wdata (exec_din_s),
    .rdata (dout_s)
  );

  assign tcm.tcm_dout      = dout_s;
  assign tcm.tcm_ready_nxt = ready_nxt_s;

endmodule

// File: tb/tb_nanorv32_tcm_responder.sv
// -----------------------------------------------------------------------------
// tb_nanorv32_tcm_responder
// Directed bench for nanorv32_tcm_responder. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, away from the rising edge.
// Builds with or without NANORV32_TCM_WAIT_STATES_EN (WAIT_CYCLES=2).
// -----------------------------------------------------------------------------
module tb_nanorv32_tcm_responder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  nanorv32_tcm_responder_if #(.ADDR_WIDTH(12)) tcm ();

  nanorv32_tcm_responder #(
    .ADDR_WIDTH  (12),
    .WAIT_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tcm (tcm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Issue one access and wait (bounded) for ready_nxt; returns at the falling
  // edge after the execute edge, with tcm_en dropped.
  task automatic access(input logic [11:0] addr, input logic [3:0] be,
                        input logic [31:0] din, output logic ok);
    int n;
    ok = 1'b0;
    n  = 0;
    @(negedge clk);
    tcm.tcm_en      = 1'b1;
    tcm.tcm_addr    = addr;
    tcm.tcm_bytesel = be;
    tcm.tcm_din     = din;
    #1;
    while (!ok && n < 16) begin
      if (tcm.tcm_ready_nxt === 1'b1) begin
        ok = 1'b1;
      end else begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    @(negedge clk);
    tcm.tcm_en      = 1'b0;
    tcm.tcm_bytesel = 4'b0000;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    tcm.tcm_en      = 1'b1;
    tcm.tcm_addr    = 12'h000;
    tcm.tcm_bytesel = 4'b0000;
    tcm.tcm_din     = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (tcm.tcm_ready_nxt !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", tcm.tcm_ready_nxt);
    end
    checks++;
    if (tcm.tcm_dout !== 32'h0) begin
      errors++; $display("FAIL reset_dout: got %h expected 00000000", tcm.tcm_dout);
    end
    @(negedge clk);
    rst        = 1'b0;
    tcm.tcm_en = 1'b0;
    #1;
    checks++;
    if (tcm.tcm_ready_nxt !== 1'b0) begin
      errors++; $display("FAIL idle_ready: got %b expected 0", tcm.tcm_ready_nxt);
    end
  endtask

  task automatic test_zero_wait();
    @(negedge clk);
    tcm.tcm_en = 1'b1; tcm.tcm_addr = 12'h010; tcm.tcm_bytesel = 4'hF; tcm.tcm_din = 32'hDEADBEEF;
    #1;
    checks++;
    if (tcm.tcm_ready_nxt !== 1'b1) begin
      errors++; $display("FAIL zw_write_ready: got %b expected 1", tcm.tcm_ready_nxt);
    end
    @(negedge clk);
    tcm.tcm_bytesel = 4'b0000;
    #1;
    checks++;
    if (tcm.tcm_ready_nxt !== 1'b1) begin
      errors++; $display("FAIL zw_read_ready: got %b expected 1", tcm.tcm_ready_nxt);
    end
    checks++;
    if (tcm.tcm_dout !== 32'h0) begin
      errors++; $display("FAIL zw_write_hold: got %h expected 00000000", tcm.tcm_dout);
    end
    @(negedge clk);
    tcm.tcm_en = 1'b0;
    #1;
    checks++;
    if (tcm.tcm_dout !== 32'hDEADBEEF) begin
      errors++; $display("FAIL zw_read_data: got %h expected deadbeef", tcm.tcm_dout);
    end
    checks++;
    if (tcm.tcm_ready_nxt !== 1'b0) begin
      errors++; $display("FAIL zw_idle_ready: got %b expected 0", tcm.tcm_ready_nxt);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    tcm.tcm_en = 1'b1; tcm.tcm_addr = 12'h100; tcm.tcm_bytesel = 4'hF; tcm.tcm_din = 32'h01234567;
    @(negedge clk);
    tcm.tcm_addr = 12'h104; tcm.tcm_din = 32'h89ABCDEF;
    @(negedge clk);
    tcm.tcm_addr = 12'h100; tcm.tcm_bytesel = 4'b0000;
    @(negedge clk);
    tcm.tcm_addr = 12'h104;
    #1;
    checks++;
    if (tcm.tcm_dout !== 32'h01234567) begin
      errors++; $display("FAIL b2b_read0: got %h expected 01234567", tcm.tcm_dout);
    end
    @(negedge clk);
    tcm.tcm_en = 1'b0;
    #1;
    checks++;
    if (tcm.tcm_dout !== 32'h89ABCDEF) begin
      errors++; $display("FAIL b2b_read1: got %h expected 89abcdef", tcm.tcm_dout);
    end
  endtask

  task automatic test_byte_lanes();
    logic ok;
    access(12'h020, 4'hF, 32'h11223344, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL bl_wr_full_ready: got %b expected 1", ok); end
    access(12'h020, 4'b0101, 32'hAABBCCDD, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL bl_wr_mask_ready: got %b expected 1", ok); end
    access(12'h020, 4'b0000, 32'h0, ok);
    checks++;
    if (tcm.tcm_dout !== 32'h11BB33DD) begin
      errors++; $display("FAIL bl_read_0101: got %h expected 11bb33dd", tcm.tcm_dout);
    end
    access(12'h020, 4'b1000, 32'h99000000, ok);
    access(12'h020, 4'b0000, 32'h0, ok);
    checks++;
    if (tcm.tcm_dout !== 32'h99BB33DD) begin
      errors++; $display("FAIL bl_read_1000: got %h expected 99bb33dd", tcm.tcm_dout);
    end
  endtask

  task automatic test_wrap();
    logic        ok;
    logic [15:0] wide;
    access(12'h004, 4'hF, 32'h12345678, ok);
    access(12'h000, 4'hF, 32'hA5A5A5A5, ok);
    access(12'hFFC, 4'hF, 32'h0F0F0F0F, ok);
    wide = 16'h1004;
    access(wide[11:0], 4'b0000, 32'h0, ok);
    checks++;
    if (tcm.tcm_dout !== 32'h12345678) begin
      errors++; $display("FAIL wrap_1004: got %h expected 12345678", tcm.tcm_dout);
    end
    access(12'h007, 4'b0000, 32'h0, ok);
    checks++;
    if (tcm.tcm_dout !== 32'h12345678) begin
      errors++; $display("FAIL wrap_007: got %h expected 12345678", tcm.tcm_dout);
    end
    access(12'h000, 4'b0000, 32'h0, ok);
    checks++;
    if (tcm.tcm_dout !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL wrap_000: got %h expected a5a5a5a5", tcm.tcm_dout);
    end
    access(12'hFFF, 4'b0000, 32'h0, ok);
    checks++;
    if (tcm.tcm_dout !== 32'h0F0F0F0F) begin
      errors++; $display("FAIL wrap_fff: got %h expected 0f0f0f0f", tcm.tcm_dout);
    end
  endtask

  task automatic test_wait_timing();
    logic [3:0] exp_ready;
    exp_ready = 4'b0100;
    @(negedge clk);
    tcm.tcm_en = 1'b1; tcm.tcm_addr = 12'h020; tcm.tcm_bytesel = 4'b0000;
    // accept, WAIT(2), WAIT(1)
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (tcm.tcm_ready_nxt !== exp_ready[i]) begin
        errors++; $display("FAIL wt_ready_c%0d: got %b expected %b", i, tcm.tcm_ready_nxt, exp_ready[i]);
      end
    end
    // DONE: new request presented but must be ignored
    @(negedge clk);
    tcm.tcm_addr = 12'h004;
    #1;
    checks++;
    if (tcm.tcm_ready_nxt !== 1'b0) begin
      errors++; $display("FAIL wt_done_ready: got %b expected 0", tcm.tcm_ready_nxt);
    end
    checks++;
    if (tcm.tcm_dout !== 32'h99BB33DD) begin
      errors++; $display("FAIL wt_read0_data: got %h expected 99bb33dd", tcm.tcm_dout);
    end
    // IDLE accept, WAIT(2), WAIT(1) for the second request
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (tcm.tcm_ready_nxt !== exp_ready[i]) begin
        errors++; $display("FAIL wt2_ready_c%0d: got %b expected %b", i, tcm.tcm_ready_nxt, exp_ready[i]);
      end
    end
    @(negedge clk);
    tcm.tcm_en = 1'b0;
    #1;
    checks++;
    if (tcm.tcm_dout !== 32'h12345678) begin
      errors++; $display("FAIL wt_read1_data: got %h expected 12345678", tcm.tcm_dout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic ok;
    access(12'h040, 4'hF, 32'hAAAA0000, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL ra_prewrite_ready: got %b expected 1", ok); end
    @(negedge clk);
    tcm.tcm_en = 1'b1; tcm.tcm_addr = 12'h040; tcm.tcm_bytesel = 4'hF; tcm.tcm_din = 32'h55555555;
`ifdef NANORV32_TCM_WAIT_STATES_EN
    #1;
    checks++;
    if (tcm.tcm_ready_nxt !== 1'b0) begin
      errors++; $display("FAIL ra_accept_ready: got %b expected 0", tcm.tcm_ready_nxt);
    end
    @(negedge clk);
`endif
    rst = 1'b1;
    #1;
    checks++;
    if (tcm.tcm_ready_nxt !== 1'b0) begin
      errors++; $display("FAIL ra_rst_ready: got %b expected 0", tcm.tcm_ready_nxt);
    end
    @(negedge clk);
    rst = 1'b0; tcm.tcm_en = 1'b0; tcm.tcm_bytesel = 4'b0000;
    #1;
    checks++;
    if (tcm.tcm_dout !== 32'h0) begin
      errors++; $display("FAIL ra_dout_cleared: got %h expected 00000000", tcm.tcm_dout);
    end
    access(12'h040, 4'b0000, 32'h0, ok);
    checks++;
    if (tcm.tcm_dout !== 32'hAAAA0000) begin
      errors++; $display("FAIL ra_no_write: got %h expected aaaa0000", tcm.tcm_dout);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
`ifndef NANORV32_TCM_WAIT_STATES_EN
    test_zero_wait();
    test_back_to_back();
`endif
    test_byte_lanes();
    test_wrap();
`ifdef NANORV32_TCM_WAIT_STATES_EN
    test_wait_timing();
`endif
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nanorv32_tcm_responder.md
NANORV32_TCM_RESPONDER -- requirements
Module: nanorv32_tcm_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, byte-address width; array depth SHALL be 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, number of inserted wait cycles per access; used only when NANORV32_TCM_WAIT_STATES_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tcm_en  input  1  access request from the arbiter side.
REQ-006 tcm_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored; word index = tcm_addr[ADDR_WIDTH-1:2].
REQ-007 tcm_bytesel  input  4  byte-lane write enables; 4'b0000 with tcm_en=1 SHALL denote a read.
REQ-008 tcm_din  input  NANORV32_DATA_MSB+1  write data; lane n = bits [8n+7:8n].
REQ-009 tcm_dout  output  NANORV32_DATA_MSB+1  registered read data.
REQ-010 tcm_ready_nxt  output  1  high in cycle C: access completes at the next edge; read data is valid on tcm_dout in cycle C+1.

Function
REQ-011 FSM states SHALL be IDLE, WAIT, DONE; state, counter and latched request SHALL be registers.
REQ-012 In IDLE with tcm_en=1, the request SHALL be accepted at the next edge.
REQ-013 Zero-wait (macro undefined, or WAIT_CYCLES=0): tcm_ready_nxt SHALL equal tcm_en in IDLE (combinational); the access SHALL execute at the next edge; FSM SHALL stay in IDLE; back-to-back accesses SHALL be accepted every cycle.
REQ-014 Wait mode (WAIT_CYCLES=W>=1): at acceptance, addr/bytesel/din SHALL be latched, the counter SHALL load W, and the FSM SHALL enter WAIT; tcm_ready_nxt SHALL be 0 in the acceptance cycle.
REQ-015 In WAIT the counter SHALL decrement each edge; tcm_ready_nxt SHALL be 1 only while counter==1; at that edge the access SHALL execute from the latched values and the FSM SHALL enter DONE.
REQ-016 DONE SHALL last exactly one cycle with tcm_ready_nxt=0 and tcm_en ignored; the FSM SHALL then return to IDLE.
REQ-017 tcm_en SHALL be ignored in WAIT and DONE; the requester SHALL hold tcm_en until it observes tcm_ready_nxt.
REQ-018 Read access: tcm_dout SHALL load mem[index] at the execute edge.
REQ-019 Write access: only lanes with bytesel[n]=1 SHALL be updated at the execute edge; tcm_dout SHALL hold its previous value.
REQ-020 A read executed in the cycle after a write to the same word SHALL return the newly written data.
REQ-021 Address wrap: any tcm_addr maps to word index modulo depth; no out-of-range error exists.

Reset
REQ-022 With rst=1 at an edge: FSM SHALL enter IDLE, counter=0, tcm_dout=0, latched request cleared; tcm_ready_nxt SHALL be 0 while rst=1.
REQ-023 Reset during WAIT SHALL abort the access; no array write SHALL occur.
REQ-024 Reset SHALL NOT clear array contents.

Configuration
REQ-025 Macro NANORV32_TCM_WAIT_STATES_EN defined: wait-state FSM per REQ-014..016 compiled in, driven by WAIT_CYCLES.
REQ-026 Macro undefined: only zero-wait behaviour (REQ-013) SHALL be compiled; WAIT_CYCLES has no effect; no FSM/counter registers SHALL exist.

Structure
REQ-027 NANORV32_DATA_MSB and the FSM state encodings SHALL reside in the shared nanorv32_parameters include.
REQ-028 The storage array SHALL be a sub-module nanorv32_tcm_sram (single-port, byte-enable write, registered read) instantiated once.

Verification
REQ-029 Zero-wait: write 0xDEADBEEF to 0x010, bytesel=4'hF; read 0x010 next cycle -> ready_nxt=1 both cycles, dout=0xDEADBEEF in the cycle after the read.
REQ-030 Byte lanes: over 0x11223344 at 0x020, write 0xAABBCCDD with bytesel=4'b0101 -> read returns 0x11BB33DD.
REQ-031 Wait mode W=2: read held on tcm_en -> ready_nxt low in accept cycle and first WAIT cycle, high in second WAIT cycle, dout valid the following cycle, one DONE cycle, next request accepted in the cycle after.
REQ-032 Reset mid-WAIT (W=3) during a write of 0x55555555 to 0x040 -> ready_nxt=0, dout=0, subsequent read of 0x040 returns prior contents.
REQ-033 Wrap: ADDR_WIDTH=12, write 0x12345678 at 0x004, read 0x1004 (bit 12 dropped) and 0x007 -> both return 0x12345678.
